// File: rtl/seg7_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------
// | seg7_pkg : segment codes, op/state encodings and helpers for seg7_calc_display
// | Revision : 1.0
// +----------------------------------------------------------------------------
package seg7_pkg;

   localparam logic [6:0] SEG_BLANK = 7'h7F;
   localparam logic [6:0] SEG_DASH  = 7'h7E;

   typedef enum logic [1:0] {
      OP_PASS = 2'b00,
      OP_ADD  = 2'b01,
      OP_MUL  = 2'b10,
      OP_SUB  = 2'b11
   } op_e;

   typedef enum logic [1:0] {
      ST_SNAP  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_LOAD  = 2'd2
   } state_e;

   function automatic logic [63:0] pow10(input int n);
      logic [63:0] r;
      r = 64'd1;
      for (int i = 0; i < n; i++) begin
         r = r * 64'd10;
      end
      return r;
   endfunction

   // Active-low {a,b,c,d,e,f,g}; non-decimal nibbles render blank
   function automatic logic [6:0] seg_code(input logic [3:0] d);
      logic [6:0] c;
      case (d)
         4'd0:    c = 7'h01;
         4'd1:    c = 7'h4F;
         4'd2:    c = 7'h12;
         4'd3:    c = 7'h06;
         4'd4:    c = 7'h4C;
         4'd5:    c = 7'h24;
         4'd6:    c = 7'h60;
         4'd7:    c = 7'h0F;
         4'd8:    c = 7'h00;
         4'd9:    c = 7'h0C;
         default: c = SEG_BLANK;
      endcase
      return c;
   endfunction

endpackage
`default_nettype wire

// File: rtl/seg7_calc_display_if.sv
`default_nettype none
// +----------------------------------------------------------------------------
// | seg7_calc_display_if : operand inputs and multiplexed display outputs
// | Revision : 1.0
// +----------------------------------------------------------------------------
interface seg7_calc_display_if #(
   parameter int NUM_DIGITS = 4,
   parameter int IN_W       = 8
);
   logic [IN_W-1:0]       a;
   logic [IN_W-1:0]       b;
   logic [1:0]            op;
   logic [6:0]            seg;
   logic [NUM_DIGITS-1:0] dig;
   logic                  dp;

   modport master (output a, output b, output op, input seg, input dig, input dp);
   modport slave  (input a, input b, input op, output seg, output dig, output dp);
endinterface
`default_nettype wire

// File: rtl/seg7_bin2bcd.sv
`default_nettype none
// +----------------------------------------------------------------------------
// | seg7_bin2bcd : iterative double-dabble, one bit per cycle, RES_W cycles
// | Revision : 1.0
// +----------------------------------------------------------------------------
module seg7_bin2bcd #(
   parameter int RES_W      = 16,
   parameter int NUM_DIGITS = 4
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    start_i,
   input  logic [RES_W-1:0]        bin_i,
   output logic [4*NUM_DIGITS-1:0] bcd_o,
   output logic                    done_o
);
   localparam int BCD_W = 4 * NUM_DIGITS;
   localparam int CNT_W = $clog2(RES_W + 1);
   localparam logic [CNT_W-1:0] LAST = CNT_W'(RES_W - 1);

   logic [RES_W-1:0] sh_q, sh_d;
   logic [BCD_W-1:0] bcd_q, bcd_d, adj_w;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             busy_q, busy_d;

   always_comb begin
      adj_w = bcd_q;
      for (int i = 0; i < NUM_DIGITS; i++) begin
         if (bcd_q[4*i +: 4] >= 4'd5) begin
            adj_w[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
         end
      end
   end

   // Digits above the register are dropped; the caller flags those values as overflow
   always_comb begin
      sh_d   = sh_q;
      bcd_d  = bcd_q;
      cnt_d  = cnt_q;
      busy_d = busy_q;
      if (start_i) begin
         sh_d   = bin_i;
         bcd_d  = '0;
         cnt_d  = '0;
         busy_d = 1'b1;
      end else if (busy_q) begin
         bcd_d = BCD_W'({adj_w, sh_q[RES_W-1]});
         sh_d  = {sh_q[RES_W-2:0], 1'b0};
         cnt_d = cnt_q + 1'b1;
         if (cnt_q == LAST) begin
            busy_d = 1'b0;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         sh_q   <= '0;
         bcd_q  <= '0;
         cnt_q  <= '0;
         busy_q <= 1'b0;
      end else begin
         sh_q   <= sh_d;
         bcd_q  <= bcd_d;
         cnt_q  <= cnt_d;
         busy_q <= busy_d;
      end
   end

   assign bcd_o  = bcd_q;
   assign done_o = busy_q && (cnt_q == LAST);

endmodule
`default_nettype wire

// File: rtl/seg7_calc_display.sv
`default_nettype none
// +----------------------------------------------------------------------------
// | seg7_calc_display : pass/add/mul/sub on two operands, shown on an N-digit
// | multiplexed 7-seg display. Option macro SEG7_LZB_EN: leading-zero blanking.
// | Revision : 1.0
// +----------------------------------------------------------------------------
module seg7_calc_display
   import seg7_pkg::*;
#(
   parameter int NUM_DIGITS  = 4,
   parameter int IN_W        = 8,
   parameter int REFRESH_DIV = 1000
) (
   input  logic                clk,
   input  logic                rst,
   seg7_calc_display_if.slave  bus
);
   localparam int RES_W = 2 * IN_W;
   localparam int PW    = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
   localparam int IW    = $clog2(NUM_DIGITS);
   localparam logic [63:0]    OVF_LIM = pow10(NUM_DIGITS);
   localparam logic [63:0]    NEG_LIM = pow10(NUM_DIGITS - 1);
   localparam logic [PW-1:0]  P_LAST  = PW'(REFRESH_DIV - 1);
   localparam logic [IW-1:0]  I_LAST  = IW'(NUM_DIGITS - 1);

   state_e state_q, state_d;
   logic   start_w, load_w, done_w;

   logic [RES_W-1:0]        res_w;
   logic                    neg_w, ovf_w, neg_q, ovf_q;
   logic [4*NUM_DIGITS-1:0] bcd_w;
   logic [6:0]              code_w [NUM_DIGITS];
   logic [6:0]              disp_q [NUM_DIGITS];
   logic [6:0]              disp_d [NUM_DIGITS];

   logic [PW-1:0]         presc_q, presc_d;
   logic [IW-1:0]         idx_q, idx_d;
   logic [6:0]            seg_q, seg_d;
   logic [NUM_DIGITS-1:0] dig_q, dig_d;

   always_comb begin
      res_w = '0;
      neg_w = 1'b0;
      unique case (bus.op)
         OP_PASS: res_w = RES_W'(bus.a);
         OP_ADD:  res_w = RES_W'(bus.a) + RES_W'(bus.b);
         OP_MUL:  res_w = RES_W'(bus.a) * RES_W'(bus.b);
         OP_SUB: begin
            if (bus.b > bus.a) begin
               neg_w = 1'b1;
               res_w = RES_W'(bus.b) - RES_W'(bus.a);
            end else begin
               res_w = RES_W'(bus.a) - RES_W'(bus.b);
            end
         end
      endcase
      // A negative value also needs the leftmost digit for its sign
      ovf_w = (64'(res_w) >= OVF_LIM) || (neg_w && (64'(res_w) >= NEG_LIM));
   end

   seg7_bin2bcd #(
      .RES_W      (RES_W),
      .NUM_DIGITS (NUM_DIGITS)
   ) u_bin2bcd (
      .clk     (clk),
      .rst     (rst),
      .start_i (start_w),
      .bin_i   (res_w),
      .bcd_o   (bcd_w),
      .done_o  (done_w)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_SNAP;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = ST_SNAP;
      case (state_q)
         ST_SNAP:  state_d = ST_SHIFT;
         ST_SHIFT: state_d = done_w ? ST_LOAD : ST_SHIFT;
         ST_LOAD:  state_d = ST_SNAP;
         default:  state_d = ST_SNAP;
      endcase
   end

   always_comb begin
      start_w = (state_q == ST_SNAP);
      load_w  = (state_q == ST_LOAD);
   end

`ifdef SEG7_LZB_EN
   int msnz_w;
`endif

   always_comb begin
`ifdef SEG7_LZB_EN
      msnz_w = 0;
      for (int i = 0; i < NUM_DIGITS; i++) begin
         if (bcd_w[4*i +: 4] != 4'd0) begin
            msnz_w = i;
         end
      end
`endif
      for (int i = 0; i < NUM_DIGITS; i++) begin
         code_w[i] = seg_code(bcd_w[4*i +: 4]);
`ifdef SEG7_LZB_EN
         if (i > msnz_w) begin
            code_w[i] = SEG_BLANK;
         end
         if (neg_q && (i == msnz_w + 1)) begin
            code_w[i] = SEG_DASH;
         end
`else
         if (neg_q && (i == NUM_DIGITS - 1)) begin
            code_w[i] = SEG_DASH;
         end
`endif
         if (ovf_q) begin
            code_w[i] = SEG_DASH;
         end
      end
   end

   always_comb begin
      disp_d = disp_q;
      if (load_w) begin
         disp_d = code_w;
      end
   end

   // Scan reads disp_d so a same-cycle load is shown immediately
   always_comb begin
      presc_d = presc_q + 1'b1;
      idx_d   = idx_q;
      seg_d   = seg_q;
      dig_d   = dig_q;
      if (presc_q == P_LAST) begin
         presc_d = '0;
         idx_d   = (idx_q == I_LAST) ? '0 : idx_q + 1'b1;
         dig_d   = {{(NUM_DIGITS-1){1'b0}}, 1'b1} << idx_d;
         seg_d   = disp_d[idx_d];
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         neg_q   <= 1'b0;
         ovf_q   <= 1'b0;
         presc_q <= '0;
         idx_q   <= '0;
         seg_q   <= SEG_BLANK;
         dig_q   <= {{(NUM_DIGITS-1){1'b0}}, 1'b1};
         for (int i = 0; i < NUM_DIGITS; i++) begin
            disp_q[i] <= SEG_BLANK;
         end
      end else begin
         if (start_w) begin
            neg_q <= neg_w;
            ovf_q <= ovf_w;
         end
         presc_q <= presc_d;
         idx_q   <= idx_d;
         seg_q   <= seg_d;
         dig_q   <= dig_d;
         disp_q  <= disp_d;
      end
   end

   assign bus.seg = seg_q;
   assign bus.dig = dig_q;
   assign bus.dp  = 1'b1;

endmodule
`default_nettype wire

// File: tb/tb_seg7_calc_display.sv
`default_nettype none
// +----------------------------------------------------------------------------
// | tb_seg7_calc_display : directed vectors for seg7_calc_display (4 digits,
// | 8-bit operands, refresh every 4 cycles). Honours SEG7_LZB_EN.
// | Revision : 1.0
// +----------------------------------------------------------------------------
module tb_seg7_calc_display;

   logic clk = 1'b0;
   logic rst = 1'b1;

   int vectors = 0;
   int fails   = 0;

   logic [6:0] cap [4];
   logic [3:0] seen;

   seg7_calc_display_if #(.NUM_DIGITS(4), .IN_W(8)) bus ();

   seg7_calc_display #(
      .NUM_DIGITS  (4),
      .IN_W        (8),
      .REFRESH_DIV (4)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      vectors++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Record each digit's code at the cycle the scan lands on it
   task automatic capture();
      logic [3:0] prev;
      prev = bus.dig;
      seen = 4'h0;
      for (int c = 0; c < 24; c++) begin
         @(negedge clk);
         if (bus.dig != prev) begin
            for (int i = 0; i < 4; i++) begin
               if (bus.dig[i]) begin
                  cap[i]  = bus.seg;
                  seen[i] = 1'b1;
               end
            end
            prev = bus.dig;
         end
      end
      chk("scan_cover", 16'(seen), 16'hF);
   endtask

   task automatic run(input string tag, input logic [7:0] a, input logic [7:0] b,
                      input logic [1:0] op, input logic [6:0] e3, input logic [6:0] e2,
                      input logic [6:0] e1, input logic [6:0] e0);
      bus.a  = a;
      bus.b  = b;
      bus.op = op;
      repeat (36) @(negedge clk);
      capture();
      chk({tag, "_d3"}, 16'(cap[3]), 16'(e3));
      chk({tag, "_d2"}, 16'(cap[2]), 16'(e2));
      chk({tag, "_d1"}, 16'(cap[1]), 16'(e1));
      chk({tag, "_d0"}, 16'(cap[0]), 16'(e0));
      chk({tag, "_dp"}, 16'(bus.dp), 16'h1);
   endtask

   initial begin
      bus.a  = 8'd0;
      bus.b  = 8'd0;
      bus.op = 2'b00;

      repeat (2) @(negedge clk);
      chk("rst_seg", 16'(bus.seg), 16'h7F);
      chk("rst_dig", 16'(bus.dig), 16'h1);
      chk("rst_dp",  16'(bus.dp),  16'h1);
      rst = 1'b0;

      // Nothing loaded before cycle 18, so scan runs over a blank display
      for (int n = 1; n <= 16; n++) begin
         @(negedge clk);
         chk("scan_dig", 16'(bus.dig), 16'(4'b0001 << ((n / 4) % 4)));
         chk("scan_blank", 16'(bus.seg), 16'h7F);
      end

`ifdef SEG7_LZB_EN
      run("mul42",   8'd7,   8'd6,   2'b10, 7'h7F, 7'h7F, 7'h4C, 7'h12);
      run("add510",  8'd255, 8'd255, 2'b01, 7'h7F, 7'h24, 7'h4F, 7'h01);
      run("sub_m6",  8'd3,   8'd9,   2'b11, 7'h7F, 7'h7F, 7'h7E, 7'h60);
      run("pass9",   8'd9,   8'd77,  2'b00, 7'h7F, 7'h7F, 7'h7F, 7'h0C);
      run("sub_zero",8'd42,  8'd42,  2'b11, 7'h7F, 7'h7F, 7'h7F, 7'h01);
`else
      run("mul42",   8'd7,   8'd6,   2'b10, 7'h01, 7'h01, 7'h4C, 7'h12);
      run("add510",  8'd255, 8'd255, 2'b01, 7'h01, 7'h24, 7'h4F, 7'h01);
      run("sub_m6",  8'd3,   8'd9,   2'b11, 7'h7E, 7'h01, 7'h01, 7'h60);
      run("pass9",   8'd9,   8'd77,  2'b00, 7'h01, 7'h01, 7'h01, 7'h0C);
      run("sub_zero",8'd42,  8'd42,  2'b11, 7'h01, 7'h01, 7'h01, 7'h01);
`endif
      run("mul9999", 8'd99,  8'd101, 2'b10, 7'h0C, 7'h0C, 7'h0C, 7'h0C);
      run("ovf1e4",  8'd100, 8'd100, 2'b10, 7'h7E, 7'h7E, 7'h7E, 7'h7E);
      run("ovf2e4",  8'd200, 8'd100, 2'b10, 7'h7E, 7'h7E, 7'h7E, 7'h7E);
      run("sub_m255",8'd0,   8'd255, 2'b11, 7'h7E, 7'h12, 7'h24, 7'h24);

      // Reset in the middle of SHIFT, with an operand change during SHIFT
      bus.a  = 8'd1;
      bus.b  = 8'd2;
      bus.op = 2'b01;
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      repeat (5) @(negedge clk);
      bus.a = 8'd4;
      repeat (2) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      chk("mid_rst_seg", 16'(bus.seg), 16'h7F);
      chk("mid_rst_dig", 16'(bus.dig), 16'h1);
      chk("mid_rst_dp",  16'(bus.dp),  16'h1);
      rst = 1'b0;
      for (int n = 0; n < 10; n++) begin
         @(negedge clk);
         chk("mid_rst_blank", 16'(bus.seg), 16'h7F);
         chk("mid_rst_dp_run", 16'(bus.dp), 16'h1);
      end
`ifdef SEG7_LZB_EN
      run("after_rst", 8'd4, 8'd2, 2'b01, 7'h7F, 7'h7F, 7'h7F, 7'h60);
`else
      run("after_rst", 8'd4, 8'd2, 2'b01, 7'h01, 7'h01, 7'h01, 7'h60);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/seg7_calc_display.md
Name: seg7_calc_display

Overview:
- Parametrised successor to the team's 2-digit add/multiply seven-segment display block.
- Computes a selectable operation on two unsigned operands: pass, add, multiply or subtract with sign.
- Converts the result to BCD with an iterative double-dabble engine and drives an N-digit time-multiplexed common-segment display.
- Sits between switch/operand inputs and the board's 7-seg module; adds overflow indication, negative results and a programmable refresh rate.

Parameters:
- NUM_DIGITS, 4, displayed digit count; legal 2..8.
- IN_W, 8, operand width in bits; result width RES_W = 2*IN_W.
- REFRESH_DIV, 1000, clk cycles each digit stays lit; legal ≥1.

Ports:
- clk  in  1  single clock; all state on its rising edge.
- rst  in  1  synchronous, active-high reset.
- a  in  IN_W  operand A, unsigned.
- b  in  IN_W  operand B, unsigned.
- op  in  2  00 pass A, 01 A+B, 10 A*B, 11 A−B.
- seg  out  7  {a,b,c,d,e,f,g}, active-low, registered.
- dig  out  NUM_DIGITS  one-hot digit enable, active-high, registered; dig[NUM_DIGITS-1] is the leftmost (most significant) digit.
- dp  out  1  constant 1 (decimal point off).

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high on rst.
- Reset values:
  - seg=7'h7F.
  - dig=1 (digit 0).
  - Prescaler=0; digit index=0.
  - Display register all BLANK.
  - FSM=SNAP.
- Segment codes (active-low):
  - 0 through 9 = 01,4F,12,06,4C,24,60,0F,00,0C.
  - BLANK=7F, DASH=7E.
- Conversion FSM runs continuously.
  - SNAP (1 cycle):
    - Samples a, b, op and computes the RES_W-bit result; add and multiply never truncate.
    - A−B: neg=(B>A), mag=|A−B|.
    - ovf=1 if mag ≥ 10^NUM_DIGITS, or if neg and mag ≥ 10^(NUM_DIGITS−1).
  - SHIFT (RES_W cycles): add-3-then-shift, one bit per cycle, into a 4*NUM_DIGITS BCD register.
  - LOAD (1 cycle): atomically writes all digit codes to the display register, then returns to SNAP.
  - Full pass = RES_W+2 cycles. An input change is visible on the display within 2*(RES_W+2) cycles.
  - Inputs changing during SHIFT are ignored until the next SNAP.
- LOAD contents:
  - ovf: every digit DASH.
  - Otherwise: BCD digits with leading zeros shown.
  - neg: leftmost digit forced to DASH.
- Scan:
  - Prescaler counts 0..REFRESH_DIV−1.
  - On terminal count: digit index increments with wrap NUM_DIGITS−1→0, prescaler clears, dig becomes one-hot of the new index, and seg takes that digit's code in the same cycle.
  - REFRESH_DIV=1 advances every cycle.
- Display register update and scan advance in the same cycle: seg shows the newly loaded code; no tearing within a digit.
- Reset asserted mid-SHIFT: conversion aborts; outputs return to reset values next edge.

Optional Feature:
- Macro SEG7_LZB_EN enables leading-zero blanking.
- Defined:
  - Leading zeros above the most significant nonzero digit are BLANK; digit 0 always shows a numeral.
  - The minus DASH sits in the digit immediately left of the most significant nonzero digit.
  - ovf display is unchanged.
- Undefined: behaviour exactly as above.

Decomposition:
- Package seg7_pkg:
  - Segment code constants (digits, BLANK, DASH).
  - op encoding enum.
  - FSM state enum.
  - Constant function pow10(n) for the overflow bounds.
- Sub-module seg7_bin2bcd: iterative double-dabble.
  - Inputs: start, bin[RES_W-1:0].
  - Outputs: bcd[4*NUM_DIGITS-1:0], done.
  - Fixed latency of RES_W cycles.

Test Plan:
- All tests use NUM_DIGITS=4, IN_W=8, REFRESH_DIV=4.
- Reset then release, no LOAD yet → seg=7F, dig=4'b0001; dig advances every 4 cycles, wrapping 1000→0001.
- a=7, b=6, op=MUL → after ≤36 cycles, digits 3..0 = 01,01,4C,12 ("0042"); with SEG7_LZB_EN = 7F,7F,4C,12.
- a=255, b=255, op=ADD → 01,24,4F,01 ("0510").
- a=3, b=9, op=SUB → 7E,01,01,60 ("-006"); with SEG7_LZB_EN = 7F,7F,7E,60.
- a=200, b=100, op=MUL (20000 ≥ 10000) → all digits 7E; a=0, b=255, op=SUB → "-255" (7E,12,24,24), not overflow.
- rst pulsed for 1 cycle in the middle of SHIFT, with a changed during SHIFT → blank display, then new value shown within 36 cycles; dp=1 throughout.
